// File: rtl/regfile_sb.sv
// ID-stage register file: two combinational read ports, a write-back port,
// a dedicated accumulator write port and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int ACC_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we1,
    input  logic              acc_we,
    input  logic [DATA_W-1:0] acc_wd,
    output logic [DATA_W-1:0] acc_rd,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              wr_collide
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ACC_A    = ADDR_W'(ACC_REG);
    localparam bit                FWD      = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                collide_q;

    // Clears first, then the set, so a new issue survives a retiring write.
    always_comb begin
        busy_next = busy;
        if (we1)      busy_next[wa1]       = 1'b0;
        if (acc_we)   busy_next[ACC_A]     = 1'b0;
        if (busy_set) busy_next[busy_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy      <= '0;
            collide_q <= 1'b0;
        end else begin
            if (we1)    regs[wa1]   <= wd1;
            if (acc_we) regs[ACC_A] <= acc_wd;
            busy      <= busy_next;
            collide_q <= we1 && acc_we && (wa1 == ACC_A);
        end
    end

    function automatic logic [DATA_W-1:0] read_sel(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] stored);
        if (FWD && acc_we && (a == ACC_A))
            return acc_wd;
        else if (FWD && we1 && (a == wa1))
            return wd1;
        else
            return stored;
    endfunction

    // A pending register being written this cycle reads as ready when its data is forwarded.
    function automatic logic busy_sel(input logic [ADDR_W-1:0] a);
        logic clearing;
        logic setting;
        clearing = (we1 && (a == wa1)) || (acc_we && (a == ACC_A));
        setting  = busy_set && (a == busy_addr);
        return busy[a] && !(FWD && clearing && !setting);
    endfunction

    always_comb begin
        rd1    = read_sel(ra1, regs[ra1]);
        rd2    = read_sel(ra2, regs[ra2]);
        acc_rd = read_sel(ACC_A, regs[ACC_A]);
        busy1  = busy_sel(ra1);
        busy2  = busy_sel(ra2);
    end

    assign wr_collide = collide_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a bypassing and a non-bypassing instance
// share all inputs so both read behaviours are checked side by side.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra1, ra2, wa1, busy_addr;
    logic [15:0] wd1, acc_wd;
    logic        we1, acc_we, busy_set;

    logic [15:0] b_rd1, b_rd2, b_acc;
    logic        b_busy1, b_busy2, b_coll;
    logic [15:0] n_rd1, n_rd2, n_acc;
    logic        n_busy1, n_busy2, n_coll;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ACC_REG(0), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .wa1(wa1), .wd1(wd1), .we1(we1), .acc_we(acc_we), .acc_wd(acc_wd),
        .acc_rd(b_acc), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy1(b_busy1), .busy2(b_busy2), .wr_collide(b_coll)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .ACC_REG(0), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
        .wa1(wa1), .wd1(wd1), .we1(we1), .acc_we(acc_we), .acc_wd(acc_wd),
        .acc_rd(n_acc), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy1(n_busy1), .busy2(n_busy2), .wr_collide(n_coll)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 0; acc_we = 0; busy_set = 0;
    endtask

    initial begin
        rst = 0; ra1 = 0; ra2 = 0; wa1 = 0; busy_addr = 0;
        wd1 = 0; acc_wd = 0; we1 = 0; acc_we = 0; busy_set = 0;
        tick();
        rst = 1;

        // reset state and basic write/read
        ra1 = 4; ra2 = 5; #1;
        check("rst_rd1", b_rd1, 0);
        check("rst_rd2", b_rd2, 0);
        check("rst_acc", b_acc, 0);
        check("rst_busy1", b_busy1, 0);
        check("rst_coll", b_coll, 0);
        we1 = 1; wa1 = 4; wd1 = 16'h4444; tick();
        wa1 = 5; wd1 = 16'h5555; tick();
        idle(); #1;
        check("wr_b_rd1", b_rd1, 16'h4444);
        check("wr_b_rd2", b_rd2, 16'h5555);
        check("wr_n_rd1", n_rd1, 16'h4444);
        check("wr_n_rd2", n_rd2, 16'h5555);

        // accumulator and collision
        acc_we = 1; acc_wd = 16'h0001; tick();
        idle(); #1;
        check("acc_rd", b_acc, 16'h0001);
        check("acc_coll0", b_coll, 0);
        acc_we = 1; acc_wd = 16'h00AA; we1 = 1; wa1 = 0; wd1 = 16'hBEEF; ra1 = 0; #1;
        check("coll_b_fwd_acc", b_acc, 16'h00AA);
        check("coll_b_fwd_rd1", b_rd1, 16'h00AA);
        check("coll_n_rd1_old", n_rd1, 16'h0001);
        tick();
        idle(); #1;
        check("coll_reg0", b_acc, 16'h00AA);
        check("coll_n_reg0", n_acc, 16'h00AA);
        check("coll_pulse_b", b_coll, 1);
        check("coll_pulse_n", n_coll, 1);
        tick();
        check("coll_clear", b_coll, 0);

        // non-colliding simultaneous writes both land
        acc_we = 1; acc_wd = 16'h0C0C; we1 = 1; wa1 = 8; wd1 = 16'h8888; tick();
        idle(); ra1 = 8; #1;
        check("dual_acc", n_acc, 16'h0C0C);
        check("dual_r8", n_rd1, 16'h8888);
        check("dual_coll", n_coll, 0);

        // bypass
        we1 = 1; wa1 = 7; wd1 = 16'h1234; ra1 = 7; ra2 = 7; #1;
        check("byp_b_rd1", b_rd1, 16'h1234);
        check("byp_b_rd2", b_rd2, 16'h1234);
        check("byp_n_rd1_old", n_rd1, 0);
        tick();
        idle(); #1;
        check("byp_n_rd1_new", n_rd1, 16'h1234);

        // scoreboard
        busy_set = 1; busy_addr = 9; tick();
        idle(); ra1 = 9; #1;
        check("sb_b_set", b_busy1, 1);
        check("sb_n_set", n_busy1, 1);
        we1 = 1; wa1 = 9; wd1 = 16'h0999; #1;
        check("sb_b_fwd_clr", b_busy1, 0);
        check("sb_n_still", n_busy1, 1);
        tick();
        idle(); #1;
        check("sb_b_cleared", b_busy1, 0);
        check("sb_n_cleared", n_busy1, 0);
        busy_set = 1; busy_addr = 3; we1 = 1; wa1 = 3; wd1 = 16'h0333; ra2 = 3; #1;
        check("sb_setclr_now", b_busy2, 0);
        tick();
        idle(); #1;
        check("sb_setwins_b", b_busy2, 1);
        check("sb_setwins_n", n_busy2, 1);
        busy_set = 1; busy_addr = 0; tick();
        idle(); ra1 = 0; #1;
        check("sb_acc_set", b_busy1, 1);
        acc_we = 1; acc_wd = 16'h00AA; #1;
        check("sb_acc_fwd", b_busy1, 0);
        check("sb_acc_n", n_busy1, 1);
        tick();
        idle(); #1;
        check("sb_acc_clr", n_busy1, 0);

        // reset mid-operation, collision pending into the reset edge
        busy_set = 1; busy_addr = 9; tick();
        acc_we = 1; acc_wd = 16'h0077; we1 = 1; wa1 = 0; busy_set = 0; tick();
        rst = 0; acc_we = 0; we1 = 1; wa1 = 6; wd1 = 16'h6666; busy_set = 1; busy_addr = 2; tick();
        rst = 1; idle(); #1;
        check("mrst_coll_b", b_coll, 0);
        check("mrst_coll_n", n_coll, 0);
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i); ra2 = 4'(i); #1;
            check($sformatf("mrst_rd1_%0d", i), b_rd1, 0);
            check($sformatf("mrst_rd2_%0d", i), n_rd2, 0);
            check($sformatf("mrst_busy1_%0d", i), b_busy1, 0);
            check($sformatf("mrst_busy2_%0d", i), n_busy2, 0);
        end

        // highest address
        acc_we = 1; acc_wd = 16'h00AA; tick();
        idle();
        we1 = 1; wa1 = 15; wd1 = 16'hFFFF; tick();
        idle(); ra2 = 15; ra1 = 14; #1;
        check("hi_rd2", b_rd2, 16'hFFFF);
        check("hi_n_rd2", n_rd2, 16'hFFFF);
        check("hi_r14", b_rd1, 0);
        check("hi_r0", b_acc, 16'h00AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
